// File: rtl/inv_sub_bytes.sv
// Byte-serial AES-128 InvSubBytes round stage: captures a 128-bit state on strt,
// maps one byte per clock through the inverse S-box, then holds done until strt drops.
module inv_sub_bytes (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         strt,
  input  logic [127:0] data,
  output logic         finish_inv_sub,
  output logic [127:0] stt_mat
);

  // Handshake: strt is a level request; finish_inv_sub rises 16 edges after the
  // capture edge and stays high (with stt_mat stable) until strt is sampled low.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  state_t       state;
  logic [127:0] in_reg;
  logic [3:0]   cnt;
  logic [6:0]   bit_ofs;
  logic [7:0]   sbox_out;

  // Byte cnt sits at bit offset 8*(15-cnt); for a 4-bit cnt, 15-cnt is ~cnt.
  assign bit_ofs  = {~cnt, 3'b000};
  assign sbox_out = INV_SBOX[in_reg[bit_ofs +: 8]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      in_reg         <= 128'd0;
      stt_mat        <= 128'd0;
      finish_inv_sub <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          finish_inv_sub <= 1'b0;
          if (strt) begin
            in_reg  <= data;
            cnt     <= 4'd0;
            stt_mat <= 128'd0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (strt) begin
            stt_mat[bit_ofs +: 8] <= sbox_out;
            cnt                   <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              state          <= DONE;
              finish_inv_sub <= 1'b1;
            end
          end else begin
            state          <= IDLE;
            stt_mat        <= 128'd0;
            cnt            <= 4'd0;
            finish_inv_sub <= 1'b0;
          end
        end
        DONE: begin
          if (strt) begin
            finish_inv_sub <= 1'b1;
          end else begin
            state          <= IDLE;
            finish_inv_sub <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          finish_inv_sub <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Bench for inv_sub_bytes: directed and random states checked against a GF(2^8)
// reference model through an expected-result queue popped on each finish rise.
module tb_inv_sub_bytes;

  logic         clk;
  logic         rst_n;
  logic         strt;
  logic [127:0] data;
  logic         finish_inv_sub;
  logic [127:0] stt_mat;

  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q[$];
  logic         prev_fin = 1'b0;

  inv_sub_bytes dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .strt           (strt),
    .data           (data),
    .finish_inv_sub (finish_inv_sub),
    .stt_mat        (stt_mat)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] b);
    logic [7:0] x;
    x = ginv(b);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox_ref(input logic [7:0] b);
    return ginv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_sub_state(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_sbox_ref(d[127-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_ref(d[127-8*i -: 8]);
    return r;
  endfunction

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %032h expected %032h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (finish_inv_sub === 1'b1 && prev_fin !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_finish: got stt_mat %032h expected no done pulse", stt_mat);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (stt_mat !== e) begin
          failures++;
          $display("FAIL result: got %032h expected %032h", stt_mat, e);
        end
      end
    end
    prev_fin = finish_inv_sub;
  end

  // ---------------- driver tasks ----------------
  task automatic run_txn(input logic [127:0] d, input logic [127:0] exp, input int hold,
                         input bit scramble);
    int c;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    strt = 1'b1;
    data = d;
    c = 0;
    while (c < 40) begin
      @(posedge clk); #1;
      c++;
      if (scramble) data = {$urandom, $urandom, $urandom, $urandom};
      if (finish_inv_sub === 1'b1) break;
    end
    check("latency", 128'(c - 1), 128'd16);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_finish", {127'd0, finish_inv_sub}, 128'd1);
      check("hold_stt_mat", stt_mat, exp);
    end
    strt = 1'b0;
    @(posedge clk); #1;
    check("drop_finish", {127'd0, finish_inv_sub}, 128'd0);
    check("drop_retain", stt_mat, exp);
  endtask

  task automatic abort_txn(input logic [127:0] d, input int bytes_done);
    @(posedge clk); #1;
    strt = 1'b1;
    data = d;
    repeat (bytes_done + 1) @(posedge clk);
    #1;
    strt = 1'b0;
    @(posedge clk); #1;
    check("abort_stt_mat", stt_mat, 128'd0);
    check("abort_finish", {127'd0, finish_inv_sub}, 128'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] rnd;
    logic [127:0] pt;
    rst_n = 1'b0;
    strt  = 1'b0;
    data  = 128'd0;
    #1;
    check("reset_finish", {127'd0, finish_inv_sub}, 128'd0);
    check("reset_stt_mat", stt_mat, 128'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_txn({16{8'h63}}, 128'h0, 2, 1'b0);
    run_txn(128'h007CED16637CED160000000000000000,
            128'h520153FF000153FF5252525252525252, 10, 1'b0);
    pt = 128'h00112233445566778899AABBCCDDEEFF;
    run_txn(sub_state(pt), pt, 1, 1'b1);

    abort_txn(128'h0123456789ABCDEF0123456789ABCDEF, 6);
    rnd = {$urandom, $urandom, $urandom, $urandom};
    run_txn(rnd, inv_sub_state(rnd), 0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      run_txn(rnd, inv_sub_state(rnd), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a run, after byte 7 has been written.
    @(posedge clk); #1;
    strt = 1'b1;
    data = 128'hFFEEDDCCBBAA99887766554433221100;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_finish", {127'd0, finish_inv_sub}, 128'd0);
    check("midrun_reset_stt_mat", stt_mat, 128'd0);
    strt = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_reset_idle_finish", {127'd0, finish_inv_sub}, 128'd0);
    check("post_reset_idle_stt_mat", stt_mat, 128'd0);

    rnd = {$urandom, $urandom, $urandom, $urandom};
    run_txn(rnd, inv_sub_state(rnd), 3, 1'b0);

    repeat (2) @(posedge clk);
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
